// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
//   op_e    : mul/div opcode select as decoded in EX
//   state_e : sequencer FSM states
//   DIV0_LO : LO value committed on any divide by zero
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> mul/div sequencer signal bundle.
//   master : EX side (drives i_* requests, observes o_* status and HI/LO)
//   slave  : sequencer side
interface ex_muldiv_sequencer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 2
);
  logic               i_start;
  logic [NB_OP-1:0]   i_op;
  logic [NB_DATA-1:0] i_data_a;
  logic [NB_DATA-1:0] i_data_b;
  logic               i_read_hilo;
  logic               i_wr_hi;
  logic               i_wr_lo;
  logic [NB_DATA-1:0] i_wr_data;
  logic               i_flush;
  logic               o_stall;
  logic               o_busy;
  logic               o_done;
  logic [NB_DATA-1:0] o_hi;
  logic [NB_DATA-1:0] o_lo;

  modport master (
    output i_start, i_op, i_data_a, i_data_b, i_read_hilo,
           i_wr_hi, i_wr_lo, i_wr_data, i_flush,
    input  o_stall, o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_data_a, i_data_b, i_read_hilo,
           i_wr_hi, i_wr_lo, i_wr_data, i_flush,
    output o_stall, o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned mul/div datapath on {acc, q}.
//   i_is_div : 1 = restoring divide step, 0 = shift-add multiply step
//   i_acc    : upper half (partial product high / partial remainder)
//   i_q      : lower half (multiplier bits / dividend-quotient bits)
//   i_b      : multiplicand or divisor magnitude
//   o_acc/o_q: pair after this iteration
module muldiv_step #(
  parameter int NB_DATA = 32
) (
  input  logic               i_is_div,
  input  logic [NB_DATA-1:0] i_acc,
  input  logic [NB_DATA-1:0] i_q,
  input  logic [NB_DATA-1:0] i_b,
  output logic [NB_DATA-1:0] o_acc,
  output logic [NB_DATA-1:0] o_q
);
  logic [NB_DATA:0] sum;
  logic [NB_DATA:0] shifted;
  logic [NB_DATA:0] trial;

  always_comb begin
    sum     = {1'b0, i_acc} + {1'b0, i_b};
    shifted = {i_acc, i_q[NB_DATA-1]};
    trial   = shifted - {1'b0, i_b};
    o_acc   = i_acc;
    o_q     = i_q;
    if (i_is_div) begin
      // Remainder stays below the divisor, so bit NB_DATA of the trial
      // difference is a clean borrow flag.
      if (!trial[NB_DATA]) begin
        o_acc = trial[NB_DATA-1:0];
        o_q   = {i_q[NB_DATA-2:0], 1'b1};
      end else begin
        o_acc = shifted[NB_DATA-1:0];
        o_q   = {i_q[NB_DATA-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add shifts back into the top of acc.
      if (i_q[0]) begin
        o_acc = sum[NB_DATA:1];
        o_q   = {sum[0], i_q[NB_DATA-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[NB_DATA-1:1]};
        o_q   = {i_acc[0], i_q[NB_DATA-1:1]};
      end
    end
  end
endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
//   i_clock : rising-edge clock
//   i_reset : synchronous active-low reset
//   bus     : EX request/status bundle (start/op/operands, MFHI/MTHI/MTLO,
//             flush in; stall/busy/done and committed HI/LO out)
// IDLE -> RUN (32 iterations) -> FIX (sign correction + HI/LO commit) -> IDLE.
module ex_muldiv_sequencer
  import ex_muldiv_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 2,
  parameter int NB_CNT  = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  ex_muldiv_sequencer_if.slave  bus
);
  state_e               state_q, state_d;
  logic [NB_CNT-1:0]    count_q;
  logic [NB_DATA-1:0]   acc_q, q_q, b_q, a_raw_q;
  logic [NB_DATA-1:0]   hi_q, lo_q;
  logic                 is_div_q, neg_q_q, neg_r_q, div0_q, done_q;
  logic [NB_DATA-1:0]   step_acc, step_q;

  op_e                  op_in;
  logic                 in_signed, in_div;
  logic [NB_DATA-1:0]   mag_a, mag_b;
  logic [2*NB_DATA-1:0] prod;
  logic [NB_DATA-1:0]   quo, rem, fix_hi, fix_lo;
  logic                 busy;

  muldiv_step #(.NB_DATA(NB_DATA)) u_step (
    .i_is_div (is_div_q),
    .i_acc    (acc_q),
    .i_q      (q_q),
    .i_b      (b_q),
    .o_acc    (step_acc),
    .o_q      (step_q)
  );

  // Operand decode for the start cycle.
  always_comb begin
    op_in     = op_e'(bus.i_op);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    mag_a     = (in_signed && bus.i_data_a[NB_DATA-1]) ? -bus.i_data_a : bus.i_data_a;
    mag_b     = (in_signed && bus.i_data_b[NB_DATA-1]) ? -bus.i_data_b : bus.i_data_b;
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod   = {acc_q, q_q};
    quo    = q_q;
    rem    = acc_q;
    if (neg_q_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_r_q) rem = -rem;
    fix_hi = prod[2*NB_DATA-1:NB_DATA];
    fix_lo = prod[NB_DATA-1:0];
    if (is_div_q) begin
      fix_hi = rem;
      fix_lo = quo;
      if (div0_q) begin
        fix_hi = a_raw_q;
        fix_lo = DIV0_LO;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!bus.i_flush && bus.i_start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.i_flush)                                state_d = ST_IDLE;
        else if (count_q == NB_CNT'(NB_DATA - 1))       state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      count_q  <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!bus.i_flush) begin
            if (bus.i_start) begin
              count_q  <= '0;
              acc_q    <= '0;
              q_q      <= mag_a;
              b_q      <= mag_b;
              a_raw_q  <= bus.i_data_a;
              is_div_q <= in_div;
              neg_q_q  <= in_signed && (bus.i_data_a[NB_DATA-1] ^ bus.i_data_b[NB_DATA-1]);
              neg_r_q  <= in_signed && bus.i_data_a[NB_DATA-1];
              div0_q   <= in_div && (bus.i_data_b == '0);
            end else begin
              if (bus.i_wr_hi) hi_q <= bus.i_wr_data;
              if (bus.i_wr_lo) lo_q <= bus.i_wr_data;
            end
          end
        end
        ST_RUN: begin
          if (!bus.i_flush) begin
            acc_q   <= step_acc;
            q_q     <= step_q;
            count_q <= count_q + 1'b1;
          end
        end
        ST_FIX: begin
          if (!bus.i_flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign bus.o_busy  = busy;
  assign bus.o_done  = done_q;
  assign bus.o_hi    = hi_q;
  assign bus.o_lo    = lo_q;
  assign bus.o_stall = busy & (bus.i_start | bus.i_read_hilo | bus.i_wr_hi | bus.i_wr_lo);

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_sequencer_if #(.NB_DATA(32), .NB_OP(2)) bus ();

  ex_muldiv_sequencer #(.NB_DATA(32), .NB_OP(2), .NB_CNT(6)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_data_a = '0; bus.i_data_b = '0;
    bus.i_read_hilo = 1'b0; bus.i_wr_hi = 1'b0; bus.i_wr_lo = 1'b0;
    bus.i_wr_data = '0; bus.i_flush = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    next_cycle();
    bus.i_start = 1'b1; bus.i_op = op; bus.i_data_a = a; bus.i_data_b = b;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      if (c == 1) bus.i_start = 1'b0;
      @(negedge clk);
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin done_cnt++; done_at = c; end
      if (c == 33) begin
        check({tag, " hi_before_commit"}, bus.o_hi, cur_hi);
        check({tag, " lo_before_commit"}, bus.o_lo, cur_lo);
      end
      if (c == 34) begin
        check({tag, " hi"}, bus.o_hi, exp_hi);
        check({tag, " lo"}, bus.o_lo, exp_lo);
      end
    end
    check({tag, " done_cycle"}, done_at, 34);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_cycles"}, busy_cnt, 33);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    next_cycle();
    bus.i_wr_hi = 1'b1; bus.i_wr_data = h;
    next_cycle();
    bus.i_wr_hi = 1'b0; bus.i_wr_lo = 1'b1; bus.i_wr_data = l;
    next_cycle();
    bus.i_wr_lo = 1'b0;
    @(negedge clk);
    check("mthi", bus.o_hi, h);
    check("mtlo", bus.o_lo, l);
    cur_hi = h;
    cur_lo = l;
  endtask

  initial begin
    int stall_cnt;
    int done_cnt;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[10] = '{OP_MULT,  32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[11] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset busy",  bus.o_busy,  0);
    check("reset done",  bus.o_done,  0);
    check("reset stall", bus.o_stall, 0);
    check("reset hi",    bus.o_hi,    0);
    check("reset lo",    bus.o_lo,    0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Hazards: second start while busy, then MFHI/MFLO held from N+5.
    stall_cnt = 0;
    done_cnt = 0;
    next_cycle();
    bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_data_a = 32'd5; bus.i_data_b = 32'd6;
    for (int c = 1; c <= 36; c++) begin
      next_cycle();
      if (c == 1) bus.i_start = 1'b0;
      if (c == 2) begin
        bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_data_a = 32'd1; bus.i_data_b = 32'd1;
      end
      if (c == 4) bus.i_start = 1'b0;
      if (c == 5) bus.i_read_hilo = 1'b1;
      if (c == 35) bus.i_read_hilo = 1'b0;
      @(negedge clk);
      if (bus.o_done) done_cnt++;
      if (c == 2) check("hz stall_on_start", bus.o_stall, 1);
      if (c == 4) check("hz stall_gap", bus.o_stall, 0);
      if (c >= 5 && c <= 33 && bus.o_stall) stall_cnt++;
      if (c == 34) begin
        check("hz stall_release", bus.o_stall, 0);
        check("hz done", bus.o_done, 1);
        check("hz lo", bus.o_lo, 32'd30);
        check("hz hi", bus.o_hi, 32'd0);
      end
    end
    check("hz stall_cycles", stall_cnt, 29);
    check("hz done_pulses", done_cnt, 1);
    cur_hi = '0;
    cur_lo = 32'd30;

    write_hilo(32'h11, 32'h22);

    // MTHI alongside start is dropped; flushing the op leaves HI/LO intact.
    next_cycle();
    bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_data_a = 32'd2; bus.i_data_b = 32'd3;
    bus.i_wr_hi = 1'b1; bus.i_wr_data = 32'h99;
    next_cycle();
    bus.i_start = 1'b0; bus.i_wr_hi = 1'b0; bus.i_flush = 1'b1;
    @(negedge clk);
    check("sw busy", bus.o_busy, 1);
    next_cycle();
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("sw busy_after_flush", bus.o_busy, 0);
    check("sw hi", bus.o_hi, 32'h11);
    check("sw lo", bus.o_lo, 32'h22);

    // Flush mid-divide at N+10.
    done_cnt = 0;
    next_cycle();
    bus.i_start = 1'b1; bus.i_op = OP_DIV; bus.i_data_a = 32'd100; bus.i_data_b = 32'd7;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      if (c == 1) bus.i_start = 1'b0;
      if (c == 10) bus.i_flush = 1'b1;
      if (c == 11) bus.i_flush = 1'b0;
      @(negedge clk);
      if (bus.o_done) done_cnt++;
      if (c == 10) check("fl busy_at_flush", bus.o_busy, 1);
      if (c == 11) begin
        check("fl busy", bus.o_busy, 0);
        check("fl hi", bus.o_hi, 32'h11);
        check("fl lo", bus.o_lo, 32'h22);
      end
    end
    check("fl no_done", done_cnt, 0);
    check("fl hi_end", bus.o_hi, 32'h11);
    check("fl lo_end", bus.o_lo, 32'h22);

    // Reset mid-divide at N+10.
    next_cycle();
    bus.i_start = 1'b1; bus.i_op = OP_DIV; bus.i_data_a = 32'd100; bus.i_data_b = 32'd7;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == 1) bus.i_start = 1'b0;
      if (c == 10) rst_n = 1'b0;
      if (c == 11) bus.i_read_hilo = 1'b1;
      if (c == 12) begin rst_n = 1'b1; bus.i_read_hilo = 1'b0; end
      @(negedge clk);
      if (c == 11) begin
        check("rs busy",  bus.o_busy,  0);
        check("rs done",  bus.o_done,  0);
        check("rs stall", bus.o_stall, 0);
        check("rs hi",    bus.o_hi,    0);
        check("rs lo",    bus.o_lo,    0);
      end
    end
    cur_hi = '0;
    cur_lo = '0;
    run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
